// File: rtl/fuel_cost_counter.sv
// Fuel dispenser cost accumulator.
// Counts synchronised flow-meter pulses during a fill, accumulates price per pulse,
// and stops the pump on preset reached, display saturation, manual stop or no-flow timeout.
module fuel_cost_counter #(
  parameter int COST_MAX    = 9999999,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        flow_pulse,
  input  logic [15:0] unit_price,
  input  logic [23:0] preset_cost,
  output logic [23:0] cost,
  output logic [15:0] volume,
  output logic        pump_on,
  output logic        done,
  output logic        busy
);

  // Timer only has to reach TIMEOUT_CYC-1, so it never needs more than clog2 bits.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [24:0]   COST_MAX_W = 25'(COST_MAX);
  localparam logic [23:0]   COST_MAX_C = 24'(COST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pulse_prev_q, pulse_prev_d;
  logic [23:0]            cost_q, cost_d;
  logic [15:0]            volume_q, volume_d;
  logic [15:0]            price_q, price_d;
  logic [23:0]            preset_q, preset_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic                   pulse_edge;
  logic [24:0]            sum;
  logic                   timer_expired;

  // Next-state logic: synchroniser, edge detect, fill accounting and FSM transitions.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], flow_pulse};
    pulse_prev_d  = sync_q[SYNC_STAGES-1];
    pulse_edge    = sync_q[SYNC_STAGES-1] & ~pulse_prev_q;
    sum           = {1'b0, cost_q} + {9'd0, price_q};
    timer_expired = (TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST);

    state_d  = state_q;
    cost_d   = cost_q;
    volume_d = volume_q;
    price_d  = price_q;
    preset_d = preset_q;
    timer_d  = timer_q;

    case (state_q)
      IDLE, DONE: begin
        // start beats a simultaneous stop; pulses here are ignored
        if (start) begin
          state_d  = PUMP;
          cost_d   = '0;
          volume_d = '0;
          timer_d  = '0;
          price_d  = unit_price;
          preset_d = preset_cost;
        end
      end
      PUMP: begin
        timer_d = timer_q + 1'b1;
        if (pulse_edge) begin
          timer_d = '0;
          if (volume_q != 16'hFFFF) volume_d = volume_q + 16'd1;
          if (sum > COST_MAX_W) begin
            cost_d  = COST_MAX_C;
            state_d = DONE;
          end else begin
            cost_d = sum[23:0];
            // Overshoot below one unit price is accepted: the pulse already flowed
            if ((preset_q != '0) && (sum >= {1'b0, preset_q})) state_d = DONE;
          end
        end
        if (stop || timer_expired) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset so the pump valve closes without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      pulse_prev_q <= 1'b0;
      cost_q       <= '0;
      volume_q     <= '0;
      price_q      <= '0;
      preset_q     <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      pulse_prev_q <= pulse_prev_d;
      cost_q       <= cost_d;
      volume_q     <= volume_d;
      price_q      <= price_d;
      preset_q     <= preset_d;
      timer_q      <= timer_d;
    end
  end

  assign cost    = cost_q;
  assign volume  = volume_q;
  assign pump_on = (state_q == PUMP);
  assign busy    = (state_q == PUMP);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_fuel_cost_counter.sv
// Self-checking bench for fuel_cost_counter with a behavioural fill model.
module tb_fuel_cost_counter;

  localparam int COST_MAX = 9999999;
  localparam int TOUT     = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        flow_pulse;
  logic [15:0] unit_price;
  logic [23:0] preset_cost;
  logic [23:0] cost;
  logic [15:0] volume;
  logic        pump_on;
  logic        done;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model of the fill: plain integers following the dispensing rules
  bit m_pump = 0;
  bit m_done = 0;
  int m_cost = 0;
  int m_vol  = 0;
  int m_price = 0;
  int m_preset = 0;

  fuel_cost_counter #(
    .COST_MAX(COST_MAX),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .flow_pulse(flow_pulse),
    .unit_price(unit_price),
    .preset_cost(preset_cost),
    .cost(cost),
    .volume(volume),
    .pump_on(pump_on),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cost"},   {8'd0, cost},    m_cost);
    chk({tag, ".volume"}, {16'd0, volume}, m_vol);
    chk({tag, ".pump"},   {31'd0, pump_on}, {31'd0, m_pump});
    chk({tag, ".busy"},   {31'd0, busy},    {31'd0, m_pump});
    chk({tag, ".done"},   {31'd0, done},    {31'd0, m_done});
  endtask

  function automatic void model_pulse();
    int sum;
    if (!m_pump) return;
    if (m_vol != 16'hFFFF) m_vol++;
    sum = m_cost + m_price;
    if (sum > COST_MAX) begin
      m_cost = COST_MAX;
      m_pump = 0;
      m_done = 1;
    end else begin
      m_cost = sum;
      if (m_preset != 0 && sum >= m_preset) begin
        m_pump = 0;
        m_done = 1;
      end
    end
  endfunction

  task automatic do_start(input int price, input int preset);
    @(negedge clk);
    unit_price  = 16'(price);
    preset_cost = 24'(preset);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    unit_price  = 16'($urandom);
    preset_cost = 24'($urandom);
    m_pump = 1; m_done = 0; m_cost = 0; m_vol = 0;
    m_price = price; m_preset = preset;
    $display("start price=%0d preset=%0d cost=%0d pump=%0b", price, preset, cost, pump_on);
  endtask

  // Full pulse: high 4 clocks, low 3 clocks; the count has landed on return
  task automatic do_pulse();
    @(negedge clk);
    flow_pulse = 1'b1;
    repeat (4) @(negedge clk);
    flow_pulse = 1'b0;
    repeat (3) @(negedge clk);
    model_pulse();
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    if (m_pump) begin
      m_pump = 0;
      m_done = 1;
    end
    $display("stop cost=%0d volume=%0d done=%0b", cost, volume, done);
  endtask

  initial begin
    int k;
    int np;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; flow_pulse = 1'b0;
    unit_price = '0; preset_cost = '0;
    repeat (3) @(negedge clk);
    chk_model("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_model("after_reset");

    // Fill with no preset, with a latency check on the first pulse
    do_start(1500, 0);
    chk_model("start1");
    flow_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("latency_before", {8'd0, cost}, 0);
    @(negedge clk);
    model_pulse();
    chk("latency_after", {8'd0, cost}, 1500);
    flow_pulse = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      do_pulse();
      $display("pulse %0d cost=%0d volume=%0d", i + 2, cost, volume);
    end
    do_stop();
    chk_model("nopreset");
    chk("nopreset.cost_abs", {8'd0, cost}, 15000);

    // Preset cutoff; 6th pulse must be ignored
    do_start(1000, 4500);
    for (int i = 0; i < 6; i++) begin
      do_pulse();
      $display("pulse %0d cost=%0d volume=%0d done=%0b", i + 1, cost, volume, done);
    end
    chk_model("preset");
    chk("preset.cost_abs", {8'd0, cost}, 5000);

    // Saturation at the display limit
    do_start(60000, 0);
    for (int i = 0; i < 167; i++) do_pulse();
    $display("saturation cost=%0d volume=%0d done=%0b", cost, volume, done);
    chk_model("saturate");
    chk("saturate.cost_abs", {8'd0, cost}, COST_MAX);

    // Timeout: done rises TOUT clocks after the pulse counts
    do_start(777, 0);
    flow_pulse = 1'b1;
    repeat (3) @(negedge clk);
    model_pulse();
    chk_model("timeout.count");
    k = 0;
    while (!done && k < 3 * TOUT) begin
      @(negedge clk);
      k++;
    end
    flow_pulse = 1'b0;
    m_pump = 0; m_done = 1;
    $display("timeout after %0d clocks cost=%0d", k, cost);
    chk("timeout.cycles", k, TOUT);
    chk_model("timeout.end");

    // Stop coinciding with the detected edge: pulse counts and fill ends
    do_start(250, 0);
    do_pulse();
    @(negedge clk);
    flow_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    flow_pulse = 1'b0;
    model_pulse();
    m_pump = 0; m_done = 1;
    $display("stop+pulse cost=%0d volume=%0d done=%0b", cost, volume, done);
    chk_model("stop_edge");

    // Start with stop in DONE: start wins, cost cleared
    @(negedge clk);
    unit_price = 16'd40; preset_cost = 24'd0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    m_pump = 1; m_done = 0; m_cost = 0; m_vol = 0; m_price = 40; m_preset = 0;
    $display("restart from done cost=%0d pump=%0b", cost, pump_on);
    chk_model("restart");

    // Asynchronous reset mid-fill
    do_pulse();
    do_pulse();
    chk_model("prereset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_pump = 0; m_done = 0; m_cost = 0; m_vol = 0;
    $display("async reset cost=%0d pump=%0b", cost, pump_on);
    chk_model("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised fills against the model
    for (int f = 0; f < 8; f++) begin
      int price;
      int preset;
      price  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5000));
      preset = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60000));
      np     = $urandom_range(1, 20);
      do_start(price, preset);
      for (int i = 0; i < np; i++) begin
        do_pulse();
        $display("fill %0d pulse %0d cost=%0d volume=%0d done=%0b", f, i + 1, cost, volume, done);
        chk_model("rand.pulse");
      end
      do_stop();
      chk_model("rand.end");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
